rr_arbiter_8: RTL and testbench
===============================

# rr_arbiter_8

Round-robin arbiter sharing one resource among eight requesters. Each cycle it accepts an 8-bit request vector and issues a registered one-hot grant plus its 3-bit binary index, the same one-hot-to-index mapping the 8-to-3 encoder path uses. A grant is held until the owner drops its request or a configurable hold limit expires. The block sits in front of any shared datapath whose select input takes a 3-bit index.

## Interface
- MAX_HOLD, 16: maximum consecutive grant cycles per ownership; 0 disables the limit. Legal range 0..255.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  8  request vector; bit i = requester i
- gnt  output  8  registered one-hot grant; all zero when idle
- gnt_idx  output  3  binary index of the set gnt bit; 3'b000 when idle
- gnt_valid  output  1  high while any grant is held
- preempt  output  1  one-cycle pulse when a grant is revoked by the hold limit

## Operation
- Internal state: FSM {IDLE, GRANT}; 3-bit priority pointer `ptr`; hold counter of width clog2(MAX_HOLD+1), minimum 1 bit.
- Reset (async, immediate): state=IDLE, ptr=0, counter=0, gnt=8'h00, gnt_idx=3'b000, gnt_valid=0, preempt=0.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, select the first set bit scanning indices ptr, ptr+1, …, ptr+7 (mod 8).
  - Load gnt/gnt_idx with the selected requester, set gnt_valid=1, clear the counter, go to GRANT.
- GRANT (owner k = gnt_idx):
  - Release: req[k]==0 → next edge goes to IDLE, gnt=0, gnt_valid=0, ptr=k+1 mod 8.
  - Timeout: MAX_HOLD≠0, req[k]==1 and counter==MAX_HOLD-1 → next edge goes to IDLE, gnt=0, gnt_valid=0, ptr=k+1 mod 8, preempt=1 for exactly that one cycle.
  - Otherwise hold the grant and increment the counter. The counter saturates and never wraps; with MAX_HOLD=0 it stays 0.
  - Changes on req bits other than k are ignored while in GRANT.
- Release and timeout on the same cycle: release wins, so preempt stays 0.
- A preempted requester that keeps req high competes again in the next IDLE cycle with lowest priority, because ptr has moved past it.
- Pointer wrap: owner 7 releases → ptr=0.
- gnt is always one-hot or zero, and gnt_idx always encodes gnt.

## Timing
- All outputs are registered and change only on rising clk or asynchronous rst.
- Request-to-grant latency is 1 cycle: req is sampled in IDLE at edge N, and gnt is visible after edge N.
- Release-to-deassert latency is 1 cycle: req[k] low sampled at edge N, and gnt is zero after edge N.
- One mandatory IDLE cycle separates consecutive grants, so the minimum period per grant is 2 cycles (1 grant + 1 idle).
- Hold limit: gnt_valid is high for at most MAX_HOLD consecutive cycles per ownership.
- preempt is high during the IDLE cycle that follows the revoked grant, and never in any other cycle.
- rst asserted mid-grant clears gnt within the same cycle, without waiting for an edge. After rst deasserts, the first arbitration starts from ptr=0.

## Test plan
- Reset: assert rst with req=8'hFF mid-GRANT → gnt=0, gnt_idx=0, gnt_valid=0, preempt=0 immediately. Release rst → first grant is gnt=8'h01, gnt_idx=0.
- Round-robin fairness: hold req=8'hFF, with each owner dropping its req bit for 1 cycle after 3 granted cycles → grant order 0,1,2,…,7,0. Each grant lasts 3 cycles followed by 1 idle cycle.
- Rotating priority: ptr=5 (after owner 4 releases), then req=8'b00001001 → grant idx 0, gnt=8'h01. Next, req=8'b10000001 with ptr=1 → grant idx 7.
- Hold limit: MAX_HOLD=4, req=8'h04 held high → gnt=8'h04 for exactly 4 cycles, then 1 idle cycle with preempt=1, then re-grant idx 2. Repeat with release and limit on the same cycle → preempt stays 0.
- MAX_HOLD=0: req=8'h10 held high for 300 cycles → gnt=8'h10 continuously with no preempt. With req=8'h30, a bit-5 request never steals the grant while bit 4 holds.
- Idle/simultaneous: req=0 for 10 cycles → gnt_valid stays 0. In a single cycle, assert req=8'h81 with ptr=0 → gnt_idx=0, then after release gnt_idx=7.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter sharing one resource among eight requesters.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req[7:0]   request vector, bit i = requester i
//   gnt[7:0]   registered one-hot grant, all zero when idle
//   gnt_idx    binary index of the set gnt bit, 3'b000 when idle
//   gnt_valid  high while any grant is held
//   preempt    one-cycle pulse in the idle cycle after a grant revoked by the
//              hold limit
//
// Parameter:
//   MAX_HOLD   maximum consecutive grant cycles per ownership (0 = unlimited)
//
// Handshake: req[k] is a level request. Once gnt[k] is seen, the owner keeps
// req[k] high for as long as it wants the resource; dropping req[k] releases
// the grant on the next edge. Other req bits are ignored while a grant is held.
//
// The FSM state is kept in the signal `state` for checkers to bind to.

module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam int CW = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);
    // Counter value on the last permitted grant cycle.
    localparam logic [CW-1:0] LIMIT = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state, state_nx;
    logic [2:0]    ptr, ptr_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    gnt_nx;
    logic [2:0]    idx_nx;
    logic          valid_nx;
    logic          pre_nx;

    logic          sel_found;
    logic [2:0]    sel_idx;
    logic [2:0]    cand;
    logic          timeout;

    // Scan requesters starting at ptr; the first set bit wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        cand      = '0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + i[2:0];
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign timeout = (MAX_HOLD != 0) && (cnt == LIMIT);

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        gnt_nx   = gnt;
        idx_nx   = gnt_idx;
        valid_nx = gnt_valid;
        pre_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nx = GRANT;
                    gnt_nx   = 8'b1 << sel_idx;
                    idx_nx   = sel_idx;
                    valid_nx = 1'b1;
                    cnt_nx   = '0;
                end
            end
            GRANT: begin
                // Release is tested first so it wins over a same-cycle timeout.
                if (!req[gnt_idx] || timeout) begin
                    state_nx = IDLE;
                    gnt_nx   = 8'h00;
                    idx_nx   = 3'b000;
                    valid_nx = 1'b0;
                    ptr_nx   = gnt_idx + 3'd1;
                    pre_nx   = req[gnt_idx];
                end else if ((MAX_HOLD != 0) && (cnt != '1)) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            cnt       <= '0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'b000;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
            gnt       <= gnt_nx;
            gnt_idx   <= idx_nx;
            gnt_valid <= valid_nx;
            preempt   <= pre_nx;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed checks of rr_arbiter_8 with MAX_HOLD = 16, 4 and 0.
//
// Ports: none (top-level bench). Three instances share clk and rst, each with
// its own request vector and outputs.

module tb_rr_arbiter_8;

    logic clk;
    logic rst;

    logic [7:0] req_a, gnt_a;
    logic [2:0] idx_a;
    logic       val_a, pre_a;

    logic [7:0] req_b, gnt_b;
    logic [2:0] idx_b;
    logic       val_b, pre_b;

    logic [7:0] req_c, gnt_c;
    logic [2:0] idx_c;
    logic       val_c, pre_c;

    int checks = 0;
    int errors = 0;

    rr_arbiter_8 #(.MAX_HOLD(16)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_idx(idx_a),
        .gnt_valid(val_a), .preempt(pre_a)
    );

    rr_arbiter_8 #(.MAX_HOLD(4)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_idx(idx_b),
        .gnt_valid(val_b), .preempt(pre_b)
    );

    rr_arbiter_8 #(.MAX_HOLD(0)) dut_c (
        .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_idx(idx_c),
        .gnt_valid(val_c), .preempt(pre_c)
    );

    // Clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       pre;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] g, input logic [2:0] i,
                           input logic v, input logic p,
                           input logic [7:0] eg, input logic [2:0] ei,
                           input logic ev, input logic ep);
        chk({name, ".gnt"}, g, eg);
        chk({name, ".gnt_idx"}, {5'b0, i}, {5'b0, ei});
        chk({name, ".gnt_valid"}, {7'b0, v}, {7'b0, ev});
        chk({name, ".preempt"}, {7'b0, p}, {7'b0, ep});
    endtask

    // Driver: present inputs at the falling edge, sample 1 time unit after rising.
    task automatic cycle(input logic [7:0] ra, input logic [7:0] rb, input logic [7:0] rc);
        @(negedge clk);
        req_a = ra;
        req_b = rb;
        req_c = rc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        req_a = 8'h00;
        req_b = 8'h00;
        req_c = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req_a = 8'h00;
        req_b = 8'h00;
        req_c = 8'h00;

        // Rotating priority, simultaneous requests and ignored non-owner bits.
        tbl[0]  = '{8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[1]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0}; // ptr -> 5
        tbl[2]  = '{8'h09, 8'h01, 3'd0, 1'b1, 1'b0}; // scan 5,6,7,0
        tbl[3]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0}; // ptr -> 1
        tbl[4]  = '{8'h81, 8'h80, 3'd7, 1'b1, 1'b0}; // scan 1..7
        tbl[5]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0}; // owner 7 wraps ptr -> 0
        tbl[6]  = '{8'h81, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[7]  = '{8'h80, 8'h00, 3'd0, 1'b0, 1'b0}; // ptr -> 1
        tbl[8]  = '{8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[9]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[11] = '{8'h0C, 8'h04, 3'd2, 1'b1, 1'b0}; // bit 3 ignored
        tbl[12] = '{8'h08, 8'h00, 3'd0, 1'b0, 1'b0}; // ptr -> 3
        tbl[13] = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[14] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

        // Reset state
        #2;
        chk_all("reset_a", gnt_a, idx_a, val_a, pre_a, 8'h00, 3'd0, 1'b0, 1'b0);
        chk_all("reset_b", gnt_b, idx_b, val_b, pre_b, 8'h00, 3'd0, 1'b0, 1'b0);
        chk_all("reset_c", gnt_c, idx_c, val_c, pre_c, 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-grant clears outputs without a clock edge.
        cycle(8'hFF, 8'h00, 8'h00);
        cycle(8'hFF, 8'h00, 8'h00);
        cycle(8'hFF, 8'h00, 8'h00);
        cycle(8'hFF, 8'h00, 8'h00); // owner 0 is still held here; bring it to owner via release
        chk_all("pre_rst_grant", gnt_a, idx_a, val_a, pre_a, 8'h01, 3'd0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", gnt_a, idx_a, val_a, pre_a, 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cycle(8'hFF, 8'h00, 8'h00);
        chk_all("post_rst_grant", gnt_a, idx_a, val_a, pre_a, 8'h01, 3'd0, 1'b1, 1'b0);

        // Table-driven vectors from ptr = 0
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].req, 8'h00, 8'h00);
            chk_all($sformatf("tbl%0d", i), gnt_a, idx_a, val_a, pre_a,
                    tbl[i].gnt, tbl[i].idx, tbl[i].valid, tbl[i].pre);
        end

        // Idle: no requests for 10 cycles
        for (int i = 0; i < 10; i++) begin
            cycle(8'h00, 8'h00, 8'h00);
            chk("idle_valid", {7'b0, val_a}, 8'h00);
        end

        // Fairness: all request, each owner drops its bit for one cycle after 3 grants.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            for (int j = 0; j < 3; j++) begin
                cycle(8'hFF, 8'h00, 8'h00);
                chk_all($sformatf("rr_k%0d_c%0d", k, j), gnt_a, idx_a, val_a, pre_a,
                        8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
            end
            cycle(8'hFF & ~(8'h01 << (k % 8)), 8'h00, 8'h00);
            chk_all($sformatf("rr_k%0d_idle", k), gnt_a, idx_a, val_a, pre_a,
                    8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Hold limit 4 with a continuous request.
        do_reset();
        for (int j = 0; j < 4; j++) begin
            cycle(8'h00, 8'h04, 8'h00);
            chk_all($sformatf("hold_c%0d", j), gnt_b, idx_b, val_b, pre_b,
                    8'h04, 3'd2, 1'b1, 1'b0);
        end
        cycle(8'h00, 8'h04, 8'h00);
        chk_all("hold_preempt", gnt_b, idx_b, val_b, pre_b, 8'h00, 3'd0, 1'b0, 1'b1);
        cycle(8'h00, 8'h04, 8'h00);
        chk_all("hold_regrant", gnt_b, idx_b, val_b, pre_b, 8'h04, 3'd2, 1'b1, 1'b0);
        // Three more held cycles bring the counter to the limit; release on that edge.
        for (int j = 0; j < 3; j++) begin
            cycle(8'h00, 8'h04, 8'h00);
            chk_all($sformatf("hold2_c%0d", j), gnt_b, idx_b, val_b, pre_b,
                    8'h04, 3'd2, 1'b1, 1'b0);
        end
        cycle(8'h00, 8'h00, 8'h00);
        chk_all("release_wins", gnt_b, idx_b, val_b, pre_b, 8'h00, 3'd0, 1'b0, 1'b0);
        cycle(8'h00, 8'h00, 8'h00);
        chk("after_release_pre", {7'b0, pre_b}, 8'h00);

        // Preempted requester loses priority: req 0x06 with owner 1 timing out -> 2 next.
        cycle(8'h00, 8'h02, 8'h00); // ptr = 3 here, scan finds 1
        for (int j = 0; j < 3; j++) cycle(8'h00, 8'h06, 8'h00);
        chk("pre_owner1", gnt_b, 8'h02);
        cycle(8'h00, 8'h06, 8'h00);
        chk("pre_owner1_pulse", {7'b0, pre_b}, 8'h01);
        cycle(8'h00, 8'h06, 8'h00);
        chk("pre_next_owner", gnt_b, 8'h04);

        // No hold limit: grant stays for 300 cycles, other bits never steal it.
        do_reset();
        for (int j = 0; j < 300; j++) begin
            cycle(8'h00, 8'h00, 8'h10);
            if (gnt_c !== 8'h10 || pre_c !== 1'b0) begin
                chk("nolimit_gnt", gnt_c, 8'h10);
                chk("nolimit_pre", {7'b0, pre_c}, 8'h00);
            end
        end
        chk_all("nolimit_end", gnt_c, idx_c, val_c, pre_c, 8'h10, 3'd4, 1'b1, 1'b0);
        for (int j = 0; j < 20; j++) begin
            cycle(8'h00, 8'h00, 8'h30);
            chk("nosteal_gnt", gnt_c, 8'h10);
        end
        cycle(8'h00, 8'h00, 8'h20);
        chk_all("nolimit_rel", gnt_c, idx_c, val_c, pre_c, 8'h00, 3'd0, 1'b0, 1'b0);
        cycle(8'h00, 8'h00, 8'h20);
        chk_all("nolimit_next", gnt_c, idx_c, val_c, pre_c, 8'h20, 3'd5, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
